// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO feeding an 8N1-style UART transmitter.
//
// Writes from the controller's TX-buffer interface land in a synchronous
// FIFO. The serializer pops the head as soon as it is idle, or on the last
// stop-bit cycle, so queued bytes go out back-to-back with no idle gap.
//
// Optional feature: define UART_TX_PARITY_EN to add a parity bit between
// the data bits and the stop bit(s). That build also adds the PARITY_ODD
// parameter.
`timescale 1ns/1ps

module uart_tx_buffer #(
  parameter int DLEN      = 8,
  parameter int DEPTH     = 16,
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 115200,
`ifdef UART_TX_PARITY_EN
  parameter int PARITY_ODD = 0,
`endif
  parameter int STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_txb_wen,
  input  logic [DLEN-1:0] i_txb_wdata,
  output logic            o_txb_full,
  output logic            o_txb_overflow,
  input  logic            i_ovf_clr,
  output logic            o_txb_empty,
  output logic            o_txd,
  output logic            o_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DLEN > 1) ? $clog2(DLEN) : 1;

  // ------------------------------------------------------------------
  // FIFO
  // ------------------------------------------------------------------
  logic [DLEN-1:0] fifo_mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;
  logic [PW-1:0]   count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            wr_acc;
  logic            pop;
  logic [DLEN-1:0] rd_data;

  // The pointers carry one extra wrap bit, so their difference is the
  // occupancy 0..DEPTH with no separate counter to keep in step.
  assign count      = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (count == PW'(DEPTH));
  assign fifo_empty = (count == '0);
  // Full is taken from the registered count, so a pop in the same cycle
  // does not make room for a write that arrives while full.
  assign wr_acc     = i_txb_wen & ~fifo_full;
  assign rd_data    = fifo_mem[rd_ptr_q[AW-1:0]];

  // Next-state for the FIFO pointers and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    // A new overflow event wins over a clear in the same cycle.
    ovf_d = (i_txb_wen & fifo_full) | (ovf_q & ~i_ovf_clr);
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= i_txb_wdata;
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_txb_full     = fifo_full;
  assign o_txb_empty    = fifo_empty;
  assign o_txb_overflow = ovf_q;

  // ------------------------------------------------------------------
  // Serializer
  // ------------------------------------------------------------------
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   baud_cnt_q, baud_cnt_d;
  logic [BW-1:0]   bit_idx_q, bit_idx_d;
  logic [DLEN-1:0] shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            busy_q, busy_d;
  logic            baud_last;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  assign baud_last = (baud_cnt_q == CW'(CLKS_PER_BIT - 1));

  // Next-state for the frame sequencer, including the FIFO pop decision.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
        end
      end

      START: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[DLEN-1:1]};
          if (bit_idx_q == BW'(DLEN - 1)) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end
`endif

      STOP: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (bit_idx_q == BW'(STOP_BITS - 1)) begin
            // Chain straight into the next frame when data is waiting.
            if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end

      default: begin
        state_d    = IDLE;
        baud_cnt_d = '0;
        bit_idx_d  = '0;
      end
    endcase

    // A pop always loads the head byte and begins a start bit.
    if (pop) begin
      shift_d    = rd_data;
      bit_idx_d  = '0;
      baud_cnt_d = '0;
      state_d    = START;
`ifdef UART_TX_PARITY_EN
      parity_d   = (^rd_data) ^ (PARITY_ODD != 0);
`endif
    end
  end

  // Line level and busy flag are decoded from the next state so both
  // outputs change on the same edge as the state register.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = parity_d;
`endif
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Serializer state and registered line outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign o_txd  = txd_q;
  assign o_busy = busy_q;

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Transmit path stage that sits directly downstream of the UART AXI4-Lite controller.
- Accepts byte writes on the controller's TX-buffer interface (wen, wdata, full, overflow) into a synchronous FIFO.
- Drains the FIFO through an 8N1-style serializer onto the UART TXD line, LSB first, one baud period per bit.

Parameters:
- DLEN, 8, data bits per frame and FIFO word width.
- DEPTH, 16, FIFO entries; must be a power of two, at least 2.
- CLK_FREQ, 100_000_000, clk frequency in Hz.
- BAUD, 115200, line rate in bit/s; localparam CLKS_PER_BIT = CLK_FREQ / BAUD (integer divide), must be at least 2.
- STOP_BITS, 1, stop bits per frame (1 or 2).

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- i_txb_wen  input  1  FIFO write request.
- i_txb_wdata  input  DLEN  FIFO write data.
- o_txb_full  output  1  FIFO holds DEPTH entries.
- o_txb_overflow  output  1  sticky: a write was attempted while full.
- i_ovf_clr  input  1  clears o_txb_overflow.
- o_txb_empty  output  1  FIFO holds 0 entries.
- o_txd  output  1  serial line, idle high, registered.
- o_busy  output  1  serializer not in IDLE.

Behaviour:
- Reset (async assert, sync release): count=0, pointers=0, o_txb_full=0, o_txb_empty=1, o_txb_overflow=0, o_txd=1, o_busy=0, FSM=IDLE, baud counter=0.
- FIFO:
  - Pointers are log2(DEPTH)+1 bits; count 0..DEPTH; full and empty decode from count.
  - Write accepted when i_txb_wen & ~full.
  - i_txb_wen & full: data dropped, overflow set next edge.
  - Full is evaluated before a same-cycle pop, so a write while full is rejected even if a pop occurs that cycle.
  - Simultaneous accepted write and pop: count unchanged.
  - i_ovf_clr and a new overflow event in the same cycle: overflow stays set.
  - Pointers wrap modulo 2*DEPTH.
- FSM (states IDLE, START, DATA, STOP):
  - IDLE: o_txd=1. If ~empty, pop the head into the shift register, load bit index 0, go to START. The pop is the same cycle as ~empty is seen.
  - START: o_txd=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: o_txd=shift[0] for CLKS_PER_BIT cycles per bit, shifting right. After bit DLEN-1, go to STOP.
  - STOP: o_txd=1 for STOP_BITS*CLKS_PER_BIT cycles. At the last cycle, if ~empty, pop and go directly to START (no idle gap); else go to IDLE.
  - Baud counter counts 0..CLKS_PER_BIT-1 and reloads to 0 on every state or bit change.
- Latency: accepted write at edge N into an empty FIFO with FSM in IDLE gives o_txb_empty=0 after N; pop and START after N+1; o_txd falls after edge N+1.
- Frame length: (1 + DLEN + STOP_BITS) * CLKS_PER_BIT cycles.
- o_busy=1 in START, DATA, and STOP.
- Reset mid-frame: o_txd returns high immediately; FIFO contents are discarded.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - Adds parameter PARITY_ODD (default 0).
  - Adds state PARITY between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - o_txd = XOR of the popped DLEN bits, XOR PARITY_ODD.
  - Frame length becomes (2 + DLEN + STOP_BITS) * CLKS_PER_BIT.
- When undefined: no PARITY state, no parameter, DATA goes directly to STOP.

Test Plan:
- Single frame: CLK_FREQ=460800, BAUD=115200 (CLKS_PER_BIT=4). Write 0xA5 once -> o_txd falls one edge after the write is seen; sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles (40 cycles total); then o_busy=0 and o_txd=1.
- Back-to-back: write 0x00 then 0xFF on consecutive cycles -> second start bit begins on the cycle right after the first frame's stop bit, with no idle cycle; o_busy stays 1 throughout.
- Overflow: DEPTH=16, writes on 18 consecutive cycles starting with the FIFO empty and FSM in IDLE:
  - writes 0..16 accepted, o_txb_full=1 after the 17th write;
  - write 17 rejected and o_txb_overflow=1;
  - i_ovf_clr pulse clears it.
- Pointer wrap: stream 40 bytes 0x00..0x27, keeping the FIFO below full -> all 40 appear on o_txd in order, uncorrupted.
- Reset mid-DATA: deassert rstn during bit 3 of a frame with 5 entries queued -> o_txd=1 and o_txb_empty=1 immediately; no further frames after release.
- Parity (UART_TX_PARITY_EN, PARITY_ODD=0): write 0x07 -> parity bit=1; with PARITY_ODD=1 -> parity bit=0; frame is 44 cycles.
